// File: rtl/regbank_pkg.sv
// Shared encodings and default sizes for the operand-fetch register bank.
package regbank_pkg;

    // Operand source select encodings
    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_DM  = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 32;

endpackage

// File: rtl/regbank_fwd_if.sv
// Operand-fetch bus: read/write/issue requests in, operands and busy flags out.
interface regbank_fwd_if
    import regbank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = $clog2(DEF_NUM_REGS)
);
    logic              stall;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic              wr_en;
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] wr_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_rd;
    logic [DATA_W-1:0] ans_ex;
    logic [DATA_W-1:0] ans_dm;
    logic [DATA_W-1:0] ans_wb;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic [DATA_W-1:0] imm;
    logic              imm_sel;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              busy_a;
    logic              busy_b;

    // Pipeline control side
    modport master (
        output stall, ra, rb, wr_en, rw, wr_data, issue_en, issue_rd,
               ans_ex, ans_dm, ans_wb, sel_a, sel_b, imm, imm_sel,
        input  a, b, busy_a, busy_b
    );

    // Register bank side
    modport slave (
        input  stall, ra, rb, wr_en, rw, wr_data, issue_en, issue_rd,
               ans_ex, ans_dm, ans_wb, sel_a, sel_b, imm, imm_sel,
        output a, b, busy_a, busy_b
    );
endinterface

// File: rtl/regbank_fwd_mux.sv
// 4:1 operand source mux: register value or one of three forwarded results.
module regbank_fwd_mux
    import regbank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] in_reg,
    input  logic [DATA_W-1:0] in_ex,
    input  logic [DATA_W-1:0] in_dm,
    input  logic [DATA_W-1:0] in_wb,
    output logic [DATA_W-1:0] y
);

    // Pick the operand source
    always_comb begin
        y = in_reg;
        case (sel)
            SEL_REG: y = in_reg;
            SEL_EX:  y = in_ex;
            SEL_DM:  y = in_dm;
            SEL_WB:  y = in_wb;
            default: y = in_reg;
        endcase
    end

endmodule

// File: rtl/regbank_fwd.sv
// Register bank with registered dual read, write-through bypass, busy
// scoreboard and per-operand forwarding / immediate selection.
module regbank_fwd
    import regbank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    regbank_fwd_if.slave  bus
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [DATA_W-1:0]   bank_q [NUM_REGS];
    logic [DATA_W-1:0]   bank_d [NUM_REGS];
    logic [DATA_W-1:0]   ar_q, ar_d, br_q, br_d;
    logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d, br_addr_q, br_addr_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [DATA_W-1:0]   b_mux;
    logic                wr_legal;

    // A write to r0 is dropped entirely when r0 is hardwired to zero
    assign wr_legal = bus.wr_en && !(ZR && (bus.rw == '0));

    // Read value as it will look after this edge: bypass pending write
    function automatic logic [DATA_W-1:0] load_val(input logic [ADDR_W-1:0] addr);
        if (ZR && (addr == '0))
            return '0;
        else if (wr_legal && (bus.rw == addr))
            return bus.wr_data;
        else
            return bank_q[addr];
    endfunction

    // Bank write
    always_comb begin
        bank_d = bank_q;
        if (wr_legal)
            bank_d[bus.rw] = bus.wr_data;
    end

    // Operand load; while stalled, refresh a held operand if its register is written
    always_comb begin
        ar_d      = ar_q;
        br_d      = br_q;
        ar_addr_d = ar_addr_q;
        br_addr_d = br_addr_q;
        if (!bus.stall) begin
            ar_d      = load_val(bus.ra);
            br_d      = load_val(bus.rb);
            ar_addr_d = bus.ra;
            br_addr_d = bus.rb;
        end else begin
            if (wr_legal && (bus.rw == ar_addr_q))
                ar_d = bus.wr_data;
            if (wr_legal && (bus.rw == br_addr_q))
                br_d = bus.wr_data;
        end
    end

    // Scoreboard: write clears, issue sets (issue applied last so it wins)
    always_comb begin
        busy_d = busy_q;
        if (wr_legal)
            busy_d[bus.rw] = 1'b0;
        if (bus.issue_en)
            busy_d[bus.issue_rd] = 1'b1;
        if (ZR)
            busy_d[0] = 1'b0;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                bank_q[i] <= '0;
            ar_q      <= '0;
            br_q      <= '0;
            ar_addr_q <= '0;
            br_addr_q <= '0;
            busy_q    <= '0;
        end else begin
            bank_q    <= bank_d;
            ar_q      <= ar_d;
            br_q      <= br_d;
            ar_addr_q <= ar_addr_d;
            br_addr_q <= br_addr_d;
            busy_q    <= busy_d;
        end
    end

    // Busy flags look at current inputs so a write this cycle already clears them
    always_comb begin
        bus.busy_a = busy_q[bus.ra] & ~(wr_legal && (bus.rw == bus.ra));
        bus.busy_b = busy_q[bus.rb] & ~(wr_legal && (bus.rw == bus.rb));
    end

    regbank_fwd_mux #(.DATA_W(DATA_W)) u_mux_a (
        .sel    (bus.sel_a),
        .in_reg (ar_q),
        .in_ex  (bus.ans_ex),
        .in_dm  (bus.ans_dm),
        .in_wb  (bus.ans_wb),
        .y      (bus.a)
    );

    regbank_fwd_mux #(.DATA_W(DATA_W)) u_mux_b (
        .sel    (bus.sel_b),
        .in_reg (br_q),
        .in_ex  (bus.ans_ex),
        .in_dm  (bus.ans_dm),
        .in_wb  (bus.ans_wb),
        .y      (b_mux)
    );

    // Immediate overrides the B operand
    always_comb begin
        bus.b = bus.imm_sel ? bus.imm : b_mux;
    end

endmodule

// File: tb/tb_regbank_fwd.sv
// Directed bench for regbank_fwd: reset, bypass, zero reg, stall refresh,
// forwarding/immediate selection and scoreboard.
module tb_regbank_fwd;

    localparam int DW = 16;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    regbank_fwd_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regbank_fwd #(.DATA_W(DW), .NUM_REGS(32), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.ra = 0; bus.rb = 0; bus.wr_en = 0; bus.rw = 0;
        bus.wr_data = 0; bus.issue_en = 0; bus.issue_rd = 0;
        bus.ans_ex = 0; bus.ans_dm = 0; bus.ans_wb = 0;
        bus.sel_a = 0; bus.sel_b = 0; bus.imm = 0; bus.imm_sel = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1;
        n_cmp++; if (bus.a !== 16'h0 || bus.b !== 16'h0) begin n_err++;
            $display("FAIL reset_ab: a=%h b=%h expected 0000 0000", bus.a, bus.b); end
        n_cmp++; if (bus.busy_a !== 1'b0 || bus.busy_b !== 1'b0) begin n_err++;
            $display("FAIL reset_busy: busy_a=%b busy_b=%b expected 0 0", bus.busy_a, bus.busy_b); end
        step();
        rst_n = 1;
        // write r5 and issue r6
        bus.wr_en = 1; bus.rw = 5; bus.wr_data = 16'h1234;
        bus.issue_en = 1; bus.issue_rd = 6;
        step();
        bus.wr_en = 0; bus.issue_en = 0; bus.ra = 5; bus.rb = 5;
        step();
        n_cmp++; if (bus.a !== 16'h1234) begin n_err++;
            $display("FAIL pre_reset_read: a=%h expected 1234", bus.a); end
        bus.ra = 6;
        #1;
        n_cmp++; if (bus.busy_a !== 1'b1) begin n_err++;
            $display("FAIL pre_reset_busy: busy_a=%b expected 1", bus.busy_a); end
        // mid-cycle reset
        #1; rst_n = 0; #1;
        n_cmp++; if (bus.a !== 16'h0 || bus.b !== 16'h0 || bus.busy_a !== 1'b0) begin n_err++;
            $display("FAIL midcycle_reset: a=%h b=%h busy_a=%b expected 0000 0000 0",
                     bus.a, bus.b, bus.busy_a); end
        step();
        rst_n = 1;
        bus.ra = 5;
        step();
        n_cmp++; if (bus.a !== 16'h0) begin n_err++;
            $display("FAIL post_reset_read: a=%h expected 0000", bus.a); end
    endtask

    task automatic test_bypass();
        idle_inputs();
        bus.wr_en = 1; bus.rw = 7; bus.wr_data = 16'hBEEF; bus.ra = 7; bus.rb = 7;
        step();
        n_cmp++; if (bus.a !== 16'hBEEF || bus.b !== 16'hBEEF) begin n_err++;
            $display("FAIL bypass: a=%h b=%h expected beef beef", bus.a, bus.b); end
        bus.wr_en = 0; bus.ra = 0;
        step();
        bus.ra = 7;
        step();
        n_cmp++; if (bus.a !== 16'hBEEF) begin n_err++;
            $display("FAIL bank_hold: a=%h expected beef", bus.a); end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        bus.ra = 7;
        step();
        bus.wr_en = 1; bus.rw = 0; bus.wr_data = 16'hFFFF; bus.ra = 0;
        step();
        n_cmp++; if (bus.a !== 16'h0) begin n_err++;
            $display("FAIL zero_bypass: a=%h expected 0000", bus.a); end
        bus.wr_en = 0;
        step();
        n_cmp++; if (bus.a !== 16'h0) begin n_err++;
            $display("FAIL zero_read: a=%h expected 0000", bus.a); end
        bus.issue_en = 1; bus.issue_rd = 0;
        step();
        bus.issue_en = 0;
        #1;
        n_cmp++; if (bus.busy_a !== 1'b0) begin n_err++;
            $display("FAIL zero_busy: busy_a=%b expected 0", bus.busy_a); end
    endtask

    task automatic test_stall();
        idle_inputs();
        bus.wr_en = 1; bus.rw = 3; bus.wr_data = 16'h0011;
        step();
        bus.wr_en = 0; bus.ra = 3;
        step();
        n_cmp++; if (bus.a !== 16'h0011) begin n_err++;
            $display("FAIL stall_load: a=%h expected 0011", bus.a); end
        bus.stall = 1; bus.wr_en = 1; bus.rw = 3; bus.wr_data = 16'h0022;
        step();
        n_cmp++; if (bus.a !== 16'h0022) begin n_err++;
            $display("FAIL stall_refresh: a=%h expected 0022", bus.a); end
        bus.wr_en = 0; bus.ra = 4;
        step();
        n_cmp++; if (bus.a !== 16'h0022) begin n_err++;
            $display("FAIL stall_hold: a=%h expected 0022", bus.a); end
        bus.stall = 0;
        step();
        n_cmp++; if (bus.a !== 16'h0000) begin n_err++;
            $display("FAIL stall_release: a=%h expected 0000", bus.a); end
    endtask

    task automatic test_fwd_imm();
        logic [DW-1:0] exp_v [4];
        exp_v[0] = 16'h0001; exp_v[1] = 16'h0002; exp_v[2] = 16'h0003; exp_v[3] = 16'h0004;
        idle_inputs();
        bus.wr_en = 1; bus.rw = 1; bus.wr_data = 16'h0001; bus.ra = 1; bus.rb = 1;
        step();
        bus.wr_en = 0;
        bus.ans_ex = 16'h0002; bus.ans_dm = 16'h0003; bus.ans_wb = 16'h0004;
        for (int s = 0; s < 4; s++) begin
            bus.sel_a = 2'(s); bus.sel_b = 2'(s);
            #1;
            n_cmp++; if (bus.a !== exp_v[s]) begin n_err++;
                $display("FAIL fwd_a sel=%0d: a=%h expected %h", s, bus.a, exp_v[s]); end
            n_cmp++; if (bus.b !== exp_v[s]) begin n_err++;
                $display("FAIL fwd_b sel=%0d: b=%h expected %h", s, bus.b, exp_v[s]); end
        end
        bus.imm_sel = 1; bus.imm = 16'h00AA;
        for (int s = 0; s < 4; s++) begin
            bus.sel_b = 2'(s);
            #1;
            n_cmp++; if (bus.b !== 16'h00AA) begin n_err++;
                $display("FAIL imm sel_b=%0d: b=%h expected 00aa", s, bus.b); end
        end
        bus.imm_sel = 0; bus.sel_a = 0; bus.sel_b = 0;
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        bus.issue_en = 1; bus.issue_rd = 9;
        step();
        bus.issue_en = 0; bus.ra = 9; bus.rb = 10;
        #1;
        n_cmp++; if (bus.busy_a !== 1'b1 || bus.busy_b !== 1'b0) begin n_err++;
            $display("FAIL sb_issue: busy_a=%b busy_b=%b expected 1 0", bus.busy_a, bus.busy_b); end
        step();
        bus.issue_en = 1; bus.issue_rd = 9;
        bus.wr_en = 1; bus.rw = 9; bus.wr_data = 16'h5555;
        step();
        bus.issue_en = 0; bus.wr_en = 0;
        #1;
        n_cmp++; if (bus.busy_a !== 1'b1) begin n_err++;
            $display("FAIL sb_set_wins: busy_a=%b expected 1", bus.busy_a); end
        bus.wr_en = 1; bus.rw = 9; bus.wr_data = 16'h6666;
        #1;
        n_cmp++; if (bus.busy_a !== 1'b0) begin n_err++;
            $display("FAIL sb_clear_comb: busy_a=%b expected 0", bus.busy_a); end
        step();
        bus.wr_en = 0;
        #1;
        n_cmp++; if (bus.busy_a !== 1'b0) begin n_err++;
            $display("FAIL sb_clear_held: busy_a=%b expected 0", bus.busy_a); end
        n_cmp++; if (bus.a !== 16'h6666) begin n_err++;
            $display("FAIL sb_write_data: a=%h expected 6666", bus.a); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_stall();
        test_fwd_imm();
        test_scoreboard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
